// File: rtl/traffic_light_pkg.sv
// Shared definitions for the traffic-light controller and its receive-side monitor:
// light encodings, phase indices, monitor error codes and default phase durations.
package traffic_light_pkg;

    localparam logic [2:0] GRN = 3'b010;
    localparam logic [2:0] YEL = 3'b001;
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] OFF = 3'b000;

    localparam int DEF_T_G0    = 1024;
    localparam int DEF_T_BLINK = 128;
    localparam int DEF_T_Y     = 512;
    localparam int DEF_T_R     = 1024;

    typedef enum logic [2:0] {
        PH_G0   = 3'd0,
        PH_OFF1 = 3'd1,
        PH_GRN2 = 3'd2,
        PH_OFF3 = 3'd3,
        PH_GRN4 = 3'd4,
        PH_YEL  = 3'd5,
        PH_RED  = 3'd6,
        PH_HUNT = 3'd7
    } phase_e;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_ENC  = 2'd1,
        ERR_TIME = 2'd2,
        ERR_SEQ  = 2'd3
    } err_code_e;

    function automatic logic [2:0] phase_light(input phase_e p);
        case (p)
            PH_G0, PH_GRN2, PH_GRN4: phase_light = GRN;
            PH_OFF1, PH_OFF3:        phase_light = OFF;
            PH_YEL:                  phase_light = YEL;
            default:                 phase_light = RED;
        endcase
    endfunction

    function automatic phase_e phase_next(input phase_e p);
        case (p)
            PH_G0:   phase_next = PH_OFF1;
            PH_OFF1: phase_next = PH_GRN2;
            PH_GRN2: phase_next = PH_OFF3;
            PH_OFF3: phase_next = PH_GRN4;
            PH_GRN4: phase_next = PH_YEL;
            PH_YEL:  phase_next = PH_RED;
            PH_RED:  phase_next = PH_G0;
            default: phase_next = PH_HUNT;
        endcase
    endfunction

    function automatic logic enc_legal(input logic [2:0] e);
        enc_legal = (e == GRN) || (e == YEL) || (e == RED) || (e == OFF);
    endfunction

endpackage

// File: rtl/tl_run_counter.sv
// Registers the sampled light encoding, flags a change against the previous sample
// and counts the length of the current run, saturating at all-ones.
module tl_run_counter
    import traffic_light_pkg::*;
#(
    parameter int CW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    enc_i,
    output logic          change_o,
    output logic [2:0]    prev_enc_o,
    output logic [CW-1:0] run_len_o
);

    logic [2:0]    enc_q;
    logic [CW-1:0] run_q;
    logic [CW-1:0] run_d;

    assign change_o   = (enc_i != enc_q);
    assign prev_enc_o = enc_q;
    assign run_len_o  = run_q;

    always_comb begin
        run_d = run_q;
        if (change_o) begin
            run_d = CW'(1);
        end else if (run_q != {CW{1'b1}}) begin
            run_d = run_q + CW'(1);
        end
    end

    // The controller leaves reset showing green, so the first green sample is not a change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enc_q <= GRN;
            run_q <= '0;
        end else begin
            enc_q <= enc_i;
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Receive-side checker that decodes the controller's light stream into a phase and
// flags timing/sequence/encoding violations. Define TL_MON_STATS_EN for err_count.
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int T_G0    = DEF_T_G0,
    parameter int T_BLINK = DEF_T_BLINK,
    parameter int T_Y     = DEF_T_Y,
    parameter int T_R     = DEF_T_R,
    parameter int CW      = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       R,
    input  logic       G,
    input  logic       Y,
    input  logic       pass,
    output logic [2:0] phase,
    output logic       locked,
    output logic       cycle_done,
    output logic       restart,
    output logic       err,
    output logic [1:0] err_code,
    output logic [7:0] err_count
);

    logic [2:0]    enc;
    logic          change;
    logic [2:0]    prev_enc;
    logic [CW-1:0] run_len;

    phase_e    phase_q, phase_d, exp_next;
    logic      locked_q, locked_d;
    logic      cycle_done_q, cycle_done_d;
    logic      restart_q, restart_d;
    logic      err_q, err_d;
    err_code_e err_code_q, err_code_d;
    logic      pass_d1_q, pass_d2_q;
    logic      pass_recent;

    assign enc         = {R, G, Y};
    assign pass_recent = pass_d1_q | pass_d2_q;

    tl_run_counter #(.CW(CW)) u_run (
        .clk        (clk),
        .rst        (rst),
        .enc_i      (enc),
        .change_o   (change),
        .prev_enc_o (prev_enc),
        .run_len_o  (run_len)
    );

    function automatic logic [CW-1:0] exp_len(input phase_e p);
        case (p)
            PH_G0:   exp_len = CW'(T_G0);
            PH_YEL:  exp_len = CW'(T_Y);
            PH_RED:  exp_len = CW'(T_R);
            default: exp_len = CW'(T_BLINK);
        endcase
    endfunction

    always_comb begin
        phase_d      = phase_q;
        locked_d     = locked_q;
        cycle_done_d = 1'b0;
        restart_d    = 1'b0;
        err_d        = 1'b0;
        err_code_d   = ERR_NONE;
        exp_next     = phase_next(phase_q);
        if (!enc_legal(enc)) begin
            err_d      = 1'b1;
            err_code_d = ERR_ENC;
            phase_d    = PH_HUNT;
            locked_d   = 1'b0;
        end else if (locked_q) begin
            if (change) begin
                if (enc == phase_light(exp_next) && run_len == exp_len(phase_q)) begin
                    phase_d      = exp_next;
                    cycle_done_d = (phase_q == PH_RED);
                end else if (enc == GRN && phase_q != PH_G0 && pass_recent) begin
                    phase_d   = PH_G0;
                    restart_d = 1'b1;
                end else begin
                    err_d      = 1'b1;
                    err_code_d = (enc != phase_light(exp_next)) ? ERR_SEQ : ERR_TIME;
                    phase_d    = PH_HUNT;
                    locked_d   = 1'b0;
                end
            end else if (run_len >= exp_len(phase_q)) begin
                // This sample makes the run one longer than the phase allows.
                err_d      = 1'b1;
                err_code_d = ERR_TIME;
                phase_d    = PH_HUNT;
                locked_d   = 1'b0;
            end
        end else if (change && enc == GRN &&
                     (prev_enc == RED ||
                      ((prev_enc == YEL || prev_enc == OFF) && pass_recent))) begin
            phase_d  = PH_G0;
            locked_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q      <= PH_G0;
            locked_q     <= 1'b1;
            cycle_done_q <= 1'b0;
            restart_q    <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= ERR_NONE;
            pass_d1_q    <= 1'b0;
            pass_d2_q    <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            locked_q     <= locked_d;
            cycle_done_q <= cycle_done_d;
            restart_q    <= restart_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            pass_d1_q    <= pass;
            pass_d2_q    <= pass_d1_q;
        end
    end

    assign phase      = phase_q;
    assign locked     = locked_q;
    assign cycle_done = cycle_done_q;
    assign restart    = restart_q;
    assign err        = err_q;
    assign err_code   = err_code_q;

`ifdef TL_MON_STATS_EN
    logic [7:0] err_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count_q <= 8'd0;
        end else if (err_d && err_count_q != 8'hFF) begin
            err_count_q <= err_count_q + 8'd1;
        end
    end

    assign err_count = err_count_q;
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor: directed scenarios plus randomized
// schedules, compared cycle by cycle against a table-driven behavioural model.
module tb_traffic_light_monitor;

    localparam int T_G0    = 1024;
    localparam int T_BLINK = 128;
    localparam int T_Y     = 512;
    localparam int T_R     = 1024;

`ifdef TL_MON_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam logic [2:0] C_G = 3'b010;
    localparam logic [2:0] C_Y = 3'b001;
    localparam logic [2:0] C_R = 3'b100;
    localparam logic [2:0] C_O = 3'b000;

    logic       clk, rst, R, G, Y, pass;
    logic [2:0] phase;
    logic       locked, cycle_done, restart, err;
    logic [1:0] err_code;
    logic [7:0] err_count;

    traffic_light_monitor #(
        .T_G0(T_G0), .T_BLINK(T_BLINK), .T_Y(T_Y), .T_R(T_R), .CW(12)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .R          (R),
        .G          (G),
        .Y          (Y),
        .pass       (pass),
        .phase      (phase),
        .locked     (locked),
        .cycle_done (cycle_done),
        .restart    (restart),
        .err        (err),
        .err_code   (err_code),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cd_seen = 0;
    int rs_seen = 0;
    int err_seen = 0;

    // Reference model state: legal schedule tables and observed-stream bookkeeping.
    int         len_tbl[7];
    logic [2:0] lt_tbl[7];
    logic [2:0] bad_tbl[4];
    int         m_phase;
    bit         m_locked;
    logic [2:0] m_prev;
    int         m_run;
    bit         m_p1, m_p2;
    int         m_errs;
    bit         e_err, e_cd, e_rs;
    logic [1:0] e_code;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_locked = 1'b1; m_prev = C_G; m_run = 0;
        m_p1 = 1'b0; m_p2 = 1'b0; m_errs = 0;
        e_err = 1'b0; e_cd = 1'b0; e_rs = 1'b0; e_code = 2'd0;
    endtask

    task automatic model_step(input logic [2:0] l, input bit p);
        bit legal, chg, recent;
        int nxt;
        legal  = (l == C_G) || (l == C_Y) || (l == C_R) || (l == C_O);
        chg    = (l != m_prev);
        recent = m_p1 | m_p2;
        nxt    = (m_phase + 1) % 7;
        e_err = 1'b0; e_cd = 1'b0; e_rs = 1'b0; e_code = 2'd0;
        if (!legal) begin
            e_err = 1'b1; e_code = 2'd1; m_locked = 1'b0; m_phase = 7;
        end else if (m_locked) begin
            if (chg) begin
                if (l == lt_tbl[nxt] && m_run == len_tbl[m_phase]) begin
                    e_cd = (m_phase == 6);
                    m_phase = nxt;
                end else if (l == C_G && m_phase != 0 && recent) begin
                    e_rs = 1'b1; m_phase = 0;
                end else begin
                    e_err = 1'b1;
                    e_code = (l != lt_tbl[nxt]) ? 2'd3 : 2'd2;
                    m_locked = 1'b0; m_phase = 7;
                end
            end else if (m_run + 1 > len_tbl[m_phase]) begin
                e_err = 1'b1; e_code = 2'd2; m_locked = 1'b0; m_phase = 7;
            end
        end else if (chg && l == C_G &&
                     (m_prev == C_R || ((m_prev == C_Y || m_prev == C_O) && recent))) begin
            m_locked = 1'b1; m_phase = 0;
        end
        if (e_err && m_errs < 255) m_errs++;
        m_run  = chg ? 1 : ((m_run < 4095) ? m_run + 1 : 4095);
        m_prev = l;
        m_p2   = m_p1;
        m_p1   = p;
    endtask

    task automatic tick(input logic [2:0] l, input bit p);
        logic [16:0] act, exp;
        {R, G, Y} = l;
        pass = p;
        @(posedge clk);
        model_step(l, p);
        #1;
        act = {phase, locked, cycle_done, restart, err, err_code, err_count};
        exp = {3'(m_phase), m_locked, e_cd, e_rs, e_err, e_code,
               (STATS ? 8'(m_errs) : 8'd0)};
        chk("cycle", 32'(act), 32'(exp));
        if (cycle_done) cd_seen++;
        if (restart) rs_seen++;
        if (err) err_seen++;
    endtask

    task automatic seg(input logic [2:0] l, input int n, input int pf, input int pt);
        for (int i = 0; i < n; i++) begin
            tick(l, (i >= pf && i <= pt && pf >= 0));
        end
    endtask

    task automatic blinks();
        seg(C_O, T_BLINK, -1, -1);
        seg(C_G, T_BLINK, -1, -1);
        seg(C_O, T_BLINK, -1, -1);
        seg(C_G, T_BLINK, -1, -1);
    endtask

    task automatic do_reset();
        {R, G, Y} = C_G;
        pass = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    int e0, c0, r0;

    initial begin
        len_tbl = '{T_G0, T_BLINK, T_BLINK, T_BLINK, T_BLINK, T_Y, T_R};
        lt_tbl  = '{C_G, C_O, C_G, C_O, C_G, C_Y, C_R};
        bad_tbl = '{3'b011, 3'b101, 3'b110, 3'b111};
        rst = 1'b1; {R, G, Y} = C_G; pass = 1'b0;
        model_reset();
        do_reset();

        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_locked", 32'(locked), 32'd1);
        chk("rst_err", 32'({err, err_code}), 32'd0);
        chk("rst_pulses", 32'({cycle_done, restart}), 32'd0);
        chk("rst_errcnt", 32'(err_count), 32'd0);

        // Two clean schedules, then the green that closes the second cycle.
        seg(C_G, T_G0, -1, -1); blinks(); seg(C_Y, T_Y, -1, -1); seg(C_R, T_R, -1, -1);
        seg(C_G, T_G0, -1, -1); blinks(); seg(C_Y, T_Y, -1, -1); seg(C_R, T_R, -1, -1);
        tick(C_G, 1'b0);
        chk("two_cycles", 32'(cd_seen), 32'd2);
        chk("clean_err", 32'(err_seen), 32'd0);

        // Pass on yellow cycle 100, controller returns to green.
        seg(C_G, T_G0 - 1, -1, -1); blinks(); seg(C_Y, 100, 99, 99);
        tick(C_G, 1'b0);
        chk("rs_pulse", 32'(restart), 32'd1);
        chk("rs_phase", 32'(phase), 32'd0);
        chk("rs_err", 32'(err), 32'd0);
        seg(C_G, T_G0 - 1, -1, -1); blinks(); seg(C_Y, T_Y, -1, -1); seg(C_R, T_R, -1, -1);
        chk("post_rs_err", 32'(err_seen), 32'd0);

        // Pass held through phase 0.
        r0 = rs_seen;
        seg(C_G, T_G0, 0, T_G0 - 1);
        tick(C_O, 1'b0);
        chk("g0pass_ph1", 32'(phase), 32'd1);
        chk("g0pass_rs", 32'(rs_seen - r0), 32'd0);
        chk("g0pass_err", 32'(err_seen), 32'd0);
        seg(C_O, T_BLINK - 1, -1, -1);

        // Short blink green in phase 2.
        seg(C_G, T_BLINK - 1, -1, -1);
        tick(C_O, 1'b0);
        chk("short_err", 32'({err, err_code}), 32'({1'b1, 2'd2}));
        chk("short_hunt", 32'({phase, locked}), 32'({3'd7, 1'b0}));
        seg(C_O, T_BLINK - 1, -1, -1); seg(C_G, T_BLINK, -1, -1);
        seg(C_Y, T_Y, -1, -1); seg(C_R, T_R, -1, -1);
        tick(C_G, 1'b0);
        chk("relock", 32'({phase, locked}), 32'({3'd0, 1'b1}));
        chk("errcnt_one", 32'(err_count), (STATS ? 32'd1 : 32'd0));

        // Encoding glitch in red, then a skipped blink after relock.
        seg(C_G, T_G0 - 1, -1, -1); blinks(); seg(C_Y, T_Y, -1, -1); seg(C_R, 500, -1, -1);
        tick(3'b110, 1'b0);
        chk("enc_err", 32'({err, err_code}), 32'({1'b1, 2'd1}));
        chk("enc_hunt", 32'(phase), 32'd7);
        seg(C_R, T_R - 501, -1, -1);
        tick(C_G, 1'b0);
        chk("enc_relock", 32'(locked), 32'd1);
        seg(C_G, T_G0 - 1, -1, -1);
        tick(C_Y, 1'b0);
        chk("seq_err", 32'({err, err_code}), 32'({1'b1, 2'd3}));
        seg(C_Y, T_Y - 1, -1, -1); seg(C_R, T_R, -1, -1);
        tick(C_G, 1'b0);

        // Yellow overrun, then reset in the middle of the run.
        seg(C_G, T_G0 - 1, -1, -1); blinks(); seg(C_Y, T_Y, -1, -1);
        tick(C_Y, 1'b0);
        chk("ovr_err", 32'({err, err_code}), 32'({1'b1, 2'd2}));
        e0 = err_seen;
        seg(C_Y, 600 - T_Y - 1, -1, -1);
        chk("ovr_once", 32'(err_seen - e0), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_state", 32'({phase, locked}), 32'({3'd0, 1'b1}));
        chk("mid_rst_err", 32'({err, err_code, cycle_done, restart}), 32'd0);
        chk("mid_rst_cnt", 32'(err_count), 32'd0);
        do_reset();

        // Randomized schedules with length faults, pass restarts and glitches.
        for (int s = 0; s < 6; s++) begin
            for (int ph = 0; ph < 7; ph++) begin
                int n, r, k;
                logic [2:0] l;
                n = len_tbl[ph];
                l = lt_tbl[ph];
                r = int'($urandom_range(0, 11));
                if (r == 0) begin
                    n = n + (($urandom_range(0, 1) == 0) ? -1 : 1);
                    seg(l, n, -1, -1);
                end else if (r == 1 && ph != 0) begin
                    k = int'($urandom_range(0, n - 1));
                    seg(l, k + 1, k, k);
                    break;
                end else if (r == 2) begin
                    k = int'($urandom_range(0, n - 2));
                    seg(l, k, -1, -1);
                    tick(bad_tbl[$urandom_range(0, 3)], 1'b0);
                    seg(l, n - k - 1, -1, -1);
                end else begin
                    seg(l, n, -1, -1);
                end
            end
        end
        tick(C_G, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Receive-side checker for the traffic-light controller.
- Watches the controller's R/G/Y outputs and its pass input, and decodes the light stream back into a phase index.
- Checks every phase duration and every phase transition against the legal schedule, and reports completed cycles, pass-induced restarts and errors.
- Sits beside traffic_light in the top level and the testbench; has no effect on the controller.

Parameters:
- T_G0, 1024, cycles of initial green (phase 0)
- T_BLINK, 128, cycles of each blink sub-phase (phases 1-4: off, green, off, green)
- T_Y, 512, cycles of yellow (phase 5)
- T_R, 1024, cycles of red (phase 6)
- CW, 12, run-length counter width; must hold max(T_*)+1

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- R  in  1  red light from controller
- G  in  1  green light from controller
- Y  in  1  yellow light from controller
- pass  in  1  pedestrian pass request, same signal the controller sees
- phase  out  3  decoded phase 0..6; 7 = HUNT (unsynchronised)
- locked  out  1  high while the monitor is synchronised
- cycle_done  out  1  one-cycle pulse when a red run of exactly T_R ends into green
- restart  out  1  one-cycle pulse on a legal pass-induced return to green
- err  out  1  one-cycle pulse on any detected violation
- err_code  out  2  valid with err: 1 ENC (more than one light on), 2 TIME (run length wrong), 3 SEQ (illegal next light)
- err_count  out  8  saturating error count (stats feature only)

Behaviour:
- Reset values: phase=0, locked=1, run counter=0, all pulses 0, err_code=0, err_count=0. After reset the controller shows green with counter 0, so the monitor starts locked in phase 0.
- Each clk, sample {R,G,Y} into a registered encoding.
  - Encodings: GRN=010, YEL=001, RED=100, OFF=000. Anything else is ENC.
  - All outputs are registered: one cycle of latency from the sampled light to any pulse.
- Run counter: increments while the encoding is unchanged; reloads to 1 on a change. Saturates at 2^CW-1.
- Expected sequence and lengths:
  - 0 GRN T_G0
  - 1 OFF T_BLINK
  - 2 GRN T_BLINK
  - 3 OFF T_BLINK
  - 4 GRN T_BLINK
  - 5 YEL T_Y
  - 6 RED T_R
  - then back to 0
- On an encoding change while locked:
  - New light matches the next phase and the run equals the expected length: advance phase. Pulse cycle_done on the 6 to 0 step.
  - New light is GRN, current phase is 1..6, and pass was high in either of the two cycles before the change: legal restart. Set phase=0, pulse restart, no length check.
  - Otherwise: err with SEQ if the light is wrong, else TIME if only the length is wrong. Go to HUNT.
- Overrun: when the run counter exceeds the expected length while the light is unchanged, err TIME immediately (once) and go to HUNT. Do not wait for the change.
- ENC: takes priority over all other checks. Err ENC; go to HUNT, or stay in HUNT if already there.
- pass during phase 0 has no effect. A green→green extension caused by pass in phase 0 is not an event.
- HUNT (phase=7, locked=0):
  - No TIME/SEQ checks. ENC is still reported.
  - Lock on the first RED→GRN or YEL/OFF→GRN change with pass-restart qualification: phase=0, run=1, locked=1.
  - Never lock mid-green.
- Simultaneous conditions: ENC beats restart beats TIME/SEQ. Only one err pulse per cycle.
- Reset mid-operation: all state returns to reset values at once, with no err pulse.

Optional Feature:
- Macro TL_MON_STATS_EN.
- Defined: err_count increments on every err pulse and saturates at 255. Cleared only by rst.
- Undefined: no counter logic; err_count tied to 0.

Decomposition:
- Shared package traffic_light_pkg holds:
  - light encoding constants GRN/YEL/RED/OFF
  - phase constants 0..6 and HUNT=7
  - err_code constants ENC/TIME/SEQ
  - default durations (shared with the controller)
- One natural sub-module, tl_run_counter: sampled-encoding register, change detect and saturating run counter. It outputs change, prev_enc and run_len.

Test Plan:
- Reset, then drive 2 full legal schedules of 3072 cycles each → phase walks 0..6 twice, cycle_done pulses exactly 2 times, err never asserted.
- Raise pass for 1 cycle at phase 5, cycle 100; controller goes green next edge → restart pulse, phase=0, no err; following schedule checks clean.
- Pass held high throughout phase 0 → no restart, no err; phase 1 entered after exactly 1024 green cycles.
- Force phase 2 green to 127 cycles → err with err_code=2, phase=7, locked=0. Relock after the next RED→GRN; err_count=1 with TL_MON_STATS_EN.
- Drive R=G=1 for 1 cycle in phase 6 → err_code=1 the next cycle, HUNT; GRN→YEL skipping blinks after relock → err_code=3.
- Yellow held 600 cycles → err TIME at run 513, a single pulse only; assert rst mid-run → all outputs at reset values, no err.
